pdm_cic_decimator: RTL and testbench

- PDM microphone front end for the 120 MHz PLL clock domain. Generates the microphone bit clock, captures the 1-bit PDM stream, and decimates it with a 3rd-order CIC filter.
- Delivers signed 16-bit PCM samples on a valid/ready stream that feeds the UART streaming stage downstream.

---
 rtl/pdm_cic_decimator.sv | 175 +++++++++++++++++
 tb/tb_pdm_cic_decimator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator
//   PDM microphone front end: generates the microphone bit clock, captures the
//   1-bit PDM stream and decimates it with a 3rd-order CIC filter. It delivers
//   signed 16-bit PCM samples on a valid/ready stream.
//
// Ports
//   clk           system clock (PLL output, 120 MHz)
//   rst           asynchronous, active-high reset
//   en            capture enable; low holds the divider and clears the filter
//   pdm_clk       microphone bit clock (registered)
//   pdm_dat       microphone data, already synchronised
//   sample_data   signed PCM sample
//   sample_valid  sample_data holds an undelivered sample
//   sample_ready  downstream accepts the sample
//   overrun       sticky: a sample was dropped because the held one was not taken
//   drop_count    (PDM_DROP_CNT_EN only) saturating count of dropped samples
//
// Build option
//   PDM_DROP_CNT_EN  adds the drop_count port and its counter.
module pdm_cic_decimator #(
  parameter int unsigned CLK_DIV      = 40,
  parameter int unsigned SAMPLE_PHASE = 39,
  parameter int unsigned DECIM_LOG2   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        pdm_clk,
  input  logic        pdm_dat,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun
`ifdef PDM_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int unsigned ACC_W = 3 * DECIM_LOG2 + 2;
  localparam int unsigned SHIFT = 3 * DECIM_LOG2 - 15;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_CAP  = DIV_W'(SAMPLE_PHASE);

  localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] PCM_MIN = ACC_W'(-32768);

  localparam logic [1:0] WARM_DONE = 2'd3;

  logic [DIV_W-1:0]        div_cnt;
  logic [DIV_W-1:0]        div_next;
  logic                    capture;
  logic [DECIM_LOG2-1:0]   dec_cnt;
  logic                    strobe;
  logic [1:0]              warm_cnt;

  logic signed [ACC_W-1:0] x_in;
  logic signed [ACC_W-1:0] int1, int2, int3;
  logic signed [ACC_W-1:0] dly1, dly2, dly3;
  logic signed [ACC_W-1:0] c1, c2, c3;
  logic signed [ACC_W-1:0] scaled;
  logic [15:0]             pcm;
  logic                    new_sample;

  always_comb begin
    div_next   = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    capture    = en && (div_cnt == DIV_CAP);
    x_in       = pdm_dat ? ACC_W'(1) : '1;

    c1         = int3 - dly1;
    c2         = c1 - dly2;
    c3         = c2 - dly3;

    scaled     = c3 >>> SHIFT;
    if (scaled > PCM_MAX) begin
      pcm = 16'h7FFF;
    end else if (scaled < PCM_MIN) begin
      pcm = 16'h8000;
    end else begin
      pcm = scaled[15:0];
    end

    new_sample = en && strobe && (warm_cnt == WARM_DONE);
  end

  // pdm_clk is registered from the value div_cnt is about to take, so the
  // registered clock tracks div_cnt with no extra cycle of skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pdm_clk <= (div_next < DIV_HALF);
    end
  end

  // CIC integrators run at the bit rate; the combs run once per window on the
  // cycle after the window's last capture, when int3 already includes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt  <= '0;
      strobe   <= 1'b0;
      warm_cnt <= '0;
      int1     <= '0;
      int2     <= '0;
      int3     <= '0;
      dly1     <= '0;
      dly2     <= '0;
      dly3     <= '0;
    end else if (!en) begin
      dec_cnt  <= '0;
      strobe   <= 1'b0;
      warm_cnt <= '0;
      int1     <= '0;
      int2     <= '0;
      int3     <= '0;
      dly1     <= '0;
      dly2     <= '0;
      dly3     <= '0;
    end else begin
      strobe <= capture && (dec_cnt == '1);
      if (capture) begin
        dec_cnt <= dec_cnt + 1'b1;
        int1    <= int1 + x_in;
        int2    <= int2 + int1;
        int3    <= int3 + int2;
      end
      if (strobe) begin
        dly1 <= int3;
        dly2 <= c1;
        dly3 <= c2;
        // The first results after a restart come from a partly filled comb
        // history and are discarded.
        if (warm_cnt != WARM_DONE) begin
          warm_cnt <= warm_cnt + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
`ifdef PDM_DROP_CNT_EN
      drop_count   <= '0;
`endif
    end else begin
      if (new_sample) begin
        if (sample_valid && !sample_ready) begin
          overrun <= 1'b1;
`ifdef PDM_DROP_CNT_EN
          if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
          end
`endif
        end else begin
          sample_data  <= pcm;
          sample_valid <= 1'b1;
        end
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
`timescale 1ns/1ps
module tb_pdm_cic_decimator;

  localparam int WIN       = 64;
  localparam int NTAP      = 190;
  localparam int SPACING   = 2560;
  localparam int FIRST_LAT = 10241;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pdm_clk;
  logic        pdm_dat;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
`ifdef PDM_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  pdm_cic_decimator #(
    .CLK_DIV      (40),
    .SAMPLE_PHASE (39),
    .DECIM_LOG2   (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pdm_clk      (pdm_clk),
    .pdm_dat      (pdm_dat),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
`ifdef PDM_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int h [NTAP];     // impulse response of three cascaded 64-tap boxcars
  int xs[$];        // captured bits as +1/-1 since the last restart
  int exp_q[$];     // expected PCM values, in delivery order
  int mode;         // 0 random, 1 ones, 2 zeros, 3 alternating
  bit drv_on;
  int epoch;
  int spc_epoch;
  int n_xfer = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output for the window ending at capture n: FIR of the bit stream with the
  // CIC impulse response, two bits of pipeline delay, >>3 and saturation.
  function automatic int model(input int n);
    int r = 0;
    int s;
    for (int j = 0; j < NTAP; j++) begin
      int idx = n - 2 - j;
      if (idx >= 0) r += h[j] * xs[idx];
    end
    s = r >>> 3;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Driver: a new bit goes out after each pdm_clk fall and is captured before
  // the next rise, so every bit pushed here is one capture in the DUT.
  initial begin
    int seen = 0;
    bit b;
    pdm_dat = 1'b0;
    forever begin
      @(negedge pdm_clk);
      #1;
      if (drv_on) begin
        if (seen != epoch) begin
          xs.delete();
          seen = epoch;
        end
        case (mode)
          0:       b = 1'($urandom_range(0, 1));
          1:       b = 1'b1;
          2:       b = 1'b0;
          default: b = (xs.size() % 2 == 0);
        endcase
        pdm_dat = b;
        xs.push_back(b ? 1 : -1);
        if ((xs.size() % WIN == 0) && (xs.size() >= 4 * WIN))
          exp_q.push_back(model(xs.size() - 1));
      end
    end
  end

  // Monitor: every transfer pops one expected value.
  initial begin
    int last = 0;
    int last_ep = -1;
    int e;
    forever begin
      @(negedge clk);
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", int'($signed(sample_data)), 99999);
        end else begin
          e = exp_q.pop_front();
          check("sample_data", int'($signed(sample_data)), e);
        end
        if (last_ep == spc_epoch) check("sample_spacing", cyc - last, SPACING);
        last    = cyc;
        last_ep = spc_epoch;
        n_xfer++;
      end
    end
  end

  task automatic wait_xfers(input int target);
    for (int i = 0; i < 6 * SPACING + 11000 && n_xfer < target; i++) @(negedge clk);
    if (n_xfer < target) check("xfer_timeout", n_xfer, target);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_first_valid(input int start);
    for (int i = 0; i < FIRST_LAT + 2000 && !sample_valid; i++) @(negedge clk);
    check("first_valid_latency", cyc - start, FIRST_LAT);
  endtask

  task automatic wait_level(input logic lvl, output int t);
    for (int i = 0; i < 100 && pdm_clk !== lvl; i++) @(negedge clk);
    t = cyc;
  endtask

  task automatic measure_pdm();
    int t0, t1, t2, t3;
    @(negedge clk);
    wait_level(1'b0, t0);
    wait_level(1'b1, t1);
    wait_level(1'b0, t2);
    wait_level(1'b1, t3);
    check("pdm_clk_high", t2 - t1, 20);
    check("pdm_clk_period", t3 - t1, 40);
  endtask

  initial begin
    int b2[127];
    int start;
    int tgt;

    foreach (b2[i]) b2[i] = 0;
    foreach (h[i]) h[i] = 0;
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++) b2[i + j]++;
    for (int i = 0; i < 127; i++)
      for (int j = 0; j < WIN; j++) h[i + j] += b2[i];

    rst = 1'b1; en = 1'b0; sample_ready = 1'b1;
    drv_on = 1'b0; mode = 1; epoch = 0; spc_epoch = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pdm_clk", int'(pdm_clk), 0);
    check("reset_valid", int'(sample_valid), 0);
    check("reset_data", int'(sample_data), 0);
    check("reset_overrun", int'(overrun), 0);
`ifdef PDM_DROP_CNT_EN
    check("reset_drop_count", int'(drop_count), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Constant ones: warm-up latency, bit clock shape, positive saturation.
    epoch++; drv_on = 1'b1; en = 1'b1; start = cyc; tgt = n_xfer + 2;
    wait_first_valid(start);
    measure_pdm();
    wait_xfers(tgt);
    check("ones_saturate", int'($signed(sample_data)), 32767);
    check("overrun_idle", int'(overrun), 0);

    mode = 2; tgt = n_xfer + 4;
    wait_xfers(tgt);
    check("zeros_saturate", int'($signed(sample_data)), -32768);

    mode = 3; tgt = n_xfer + 3;
    wait_xfers(tgt);
    check("alternating_zero", int'($signed(sample_data)), 0);

    mode = 0; tgt = n_xfer + 3;
    wait_xfers(tgt);

    // Overrun: hold ready low across three strobes.
    sample_ready = 1'b0;
    for (int i = 0; i < 3 * SPACING + 3000 && exp_q.size() < 3; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    check("window_timeout", exp_q.size(), 3);
    check("held_valid", int'(sample_valid), 1);
    if (exp_q.size() > 0) check("held_data", int'($signed(sample_data)), exp_q[0]);
    check("overrun_set", int'(overrun), 1);
`ifdef PDM_DROP_CNT_EN
    check("drop_count", int'(drop_count), 2);
`endif
    if (exp_q.size() >= 3) begin
      exp_q.delete(2);
      exp_q.delete(1);
    end
    spc_epoch++;
    @(posedge clk);
    #1;
    sample_ready = 1'b1;
    tgt = n_xfer + 1;
    wait_xfers(tgt);
    spc_epoch++;
    tgt = n_xfer + 1;
    wait_xfers(tgt);
    check("overrun_sticky", int'(overrun), 1);

    // en low mid-window.
    repeat (1000) @(posedge clk);
    #1;
    check("pdm_clk_high_before_disable", int'(pdm_clk), 1);
    drv_on = 1'b0; en = 1'b0;
    @(posedge clk);
    #1;
    check("disable_pdm_clk", int'(pdm_clk), 0);
    repeat (50) @(posedge clk);
    #1;
    check("disable_pdm_clk_held", int'(pdm_clk), 0);
    epoch++; spc_epoch++; mode = 1; drv_on = 1'b1; en = 1'b1;
    start = cyc; tgt = n_xfer + 1;
    wait_first_valid(start);
    wait_xfers(tgt);
    check("restart_ones", int'($signed(sample_data)), 32767);

    // Reset mid-window.
    repeat (1000) @(posedge clk);
    #1;
    check("pdm_clk_high_before_reset", int'(pdm_clk), 1);
    drv_on = 1'b0; rst = 1'b1;
    #1;
    check("async_reset_pdm_clk", int'(pdm_clk), 0);
    check("async_reset_data", int'(sample_data), 0);
    check("async_reset_valid", int'(sample_valid), 0);
    check("async_reset_overrun", int'(overrun), 0);
`ifdef PDM_DROP_CNT_EN
    check("async_reset_drop_count", int'(drop_count), 0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1;
    epoch++; spc_epoch++; mode = 0; drv_on = 1'b1; rst = 1'b0;
    start = cyc; tgt = n_xfer + 2;
    wait_first_valid(start);
    wait_xfers(tgt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
